bist_sequencer: RTL and testbench
=================================

Name: bist_sequencer

Overview:
- Built-in self-test sequencer in the 90 MHz domain, directly upstream of the command FIFO and downstream of the response FIFO.
- On a start request it writes a deterministic pattern to a block of BRAM addresses through the memory controller.
- It then reads the same addresses back, compares every response, and reports pass/fail, error count, first failing address and timeout.

Parameters:
- NUM_WORDS, 16: number of addresses tested, range 1..256.
- BASE_ADDR, 8'h00: first address; address k = (BASE_ADDR + k) mod 256.
- SEED, 8'hA5: pattern key; data for address a = a ^ SEED.
- TIMEOUT_CYCLES, 4096: idle cycles allowed without progress before abort.

Ports:
- clk_90mhz  in  1  90 MHz clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- start  in  1  already synchronised to clk_90mhz; rising edge starts a test.
- cmd_fifo_wr_en  out  1  command FIFO write strobe.
- cmd_fifo_data  out  17  [16]=op (1 write, 0 read), [15:8]=address, [7:0]=write data (0 for reads).
- cmd_fifo_full  in  1  command FIFO full.
- resp_fifo_rd_en  out  1  response FIFO read strobe.
- resp_fifo_data  in  8  read data; valid the cycle after rd_en.
- resp_fifo_empty  in  1  response FIFO empty.
- busy  out  1  test in progress.
- done  out  1  sticky, set at test end.
- pass  out  1  valid while done=1.
- timeout  out  1  sticky abort flag.
- err_count  out  8  mismatches, saturating at 255.
- first_err_addr  out  8  address of the first mismatch.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - State returns to IDLE.
  - All outputs are 0; cmd_fifo_data is 0.
  - Counters are cleared.
  - A reset mid-test aborts immediately with no further FIFO strobes; done stays 0.
- Edge detect: a registered copy of start is kept; a start rising edge is acted on only in IDLE or DONE. Edges in any other state are ignored.
- IDLE/DONE + start edge:
  - Clear done, pass, timeout, err_count, first_err_addr, and all counters.
  - busy=1 on the next cycle; go to WRITE.
- WRITE:
  - Each cycle with cmd_fifo_full=0, assert cmd_fifo_wr_en with {1, addr_k, addr_k^SEED} and increment wr_idx.
  - With full=1, wr_en=0 and the data is held.
  - After the write with wr_idx = NUM_WORDS-1, go to READ with wr_idx=0.
  - Peak rate is one command per cycle.
- READ:
  - Issue {0, addr_k, 8'h00} under the same full rule.
  - After the last read is issued, go to DRAIN.
  - The response path runs concurrently.
- Response path (READ and DRAIN only):
  - Assert resp_fifo_rd_en for one cycle when resp_fifo_empty=0, no capture is pending, and rsp_idx < NUM_WORDS.
  - Next cycle, compare resp_fifo_data with (BASE_ADDR+rsp_idx)^SEED, then increment rsp_idx.
  - rd_en is never asserted in a capture cycle, so the maximum rate is one response per 2 cycles.
  - Responses are strictly in issue order.
  - On mismatch: err_count increments, saturating at 255. If it was 0, first_err_addr takes the address.
- DRAIN → DONE when rsp_idx reaches NUM_WORDS after the final capture. In DONE: done=1, busy=0, pass=(err_count==0).
- Timeout:
  - The counter is cleared on every wr_en, every command issue and every capture.
  - It increments otherwise in WRITE/READ/DRAIN.
  - On reaching TIMEOUT_CYCLES-1: go to DONE with timeout=1, pass=0.
  - Stuck full and missing responses both end this way.
- Data in resp_fifo while IDLE/DONE is left unread.
- Width: indices are 9 bits, so NUM_WORDS=256 is legal; address arithmetic is 8-bit wrap.

Test Plan:
- Defaults, ideal loopback memory: start pulse → 16 writes (first {1,00,A5}, last {1,0F,AA}), 16 reads, done=1, pass=1, err_count=0, busy high throughout the run.
- Memory model corrupts address 0x05 (returns 0x00 instead of 0xA0) and 0x09 → err_count=2, first_err_addr=0x05, pass=0.
- cmd_fifo_full held high 20 cycles after the 3rd write → no wr_en during full, no duplicate or skipped command, final pass=1.
- Responses withheld after 10 reads answered, TIMEOUT_CYCLES=64 → timeout=1, done=1, pass=0 within 64 cycles of the last capture.
- Second start edge mid-READ is ignored; sys_rst_n pulsed mid-WRITE → outputs 0 at once; a fresh start then completes pass=1.
- BASE_ADDR=8'hF8, NUM_WORDS=16 → addresses wrap F8..FF,00..07; all responses match, pass=1.

Source files
------------

// File: rtl/bist_sequencer.sv
// BIST sequencer: writes a keyed pattern to a BRAM window through the command FIFO,
// reads it back through the response FIFO and reports pass/fail, errors and timeout.
module bist_sequencer #(
    parameter int unsigned NUM_WORDS      = 16,
    parameter logic [7:0]  BASE_ADDR      = 8'h00,
    parameter logic [7:0]  SEED           = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_90mhz,
    input  logic        sys_rst_n,
    input  logic        start,
    output logic        cmd_fifo_wr_en,
    output logic [16:0] cmd_fifo_data,
    input  logic        cmd_fifo_full,
    output logic        resp_fifo_rd_en,
    input  logic [7:0]  resp_fifo_data,
    input  logic        resp_fifo_empty,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [7:0]  err_count,
    output logic [7:0]  first_err_addr
);
    localparam int            TW      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [8:0]    LAST    = 9'(NUM_WORDS - 1);
    localparam logic [8:0]    NW9     = 9'(NUM_WORDS);
    localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t        state, state_nxt;
    logic          start_q;
    logic [8:0]    wr_idx, rsp_idx;
    logic          cap_pend;
    logic [TW-1:0] tmo_cnt;

    logic       start_edge, active, issuing, rsp_phase, capture, mismatch, tmo_hit, restart;
    logic [7:0] wr_addr, rsp_addr;

    assign start_edge = start & ~start_q;
    assign active     = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
    assign rsp_phase  = (state == S_READ) || (state == S_DRAIN);
    assign restart    = ((state == S_IDLE) || (state == S_DONE)) && start_edge;
    assign wr_addr    = BASE_ADDR + wr_idx[7:0];
    assign rsp_addr   = BASE_ADDR + rsp_idx[7:0];
    assign issuing    = ((state == S_WRITE) || (state == S_READ)) && !cmd_fifo_full;
    assign capture    = cap_pend && rsp_phase;
    assign mismatch   = capture && (resp_fifo_data != (rsp_addr ^ SEED));
    // The counter saturating at TIMEOUT_CYCLES-1 is what ends the test, so trip one step early.
    assign tmo_hit    = active && !issuing && !capture && (tmo_cnt >= TMO_LIM);

    always_comb begin
        cmd_fifo_data = '0;
        if (state == S_WRITE)
            cmd_fifo_data = {1'b1, wr_addr, wr_addr ^ SEED};
        else if (state == S_READ)
            cmd_fifo_data = {1'b0, wr_addr, 8'h00};
    end

    assign cmd_fifo_wr_en  = issuing;
    // Never pop in a capture cycle: one response per two cycles keeps data/index aligned.
    assign resp_fifo_rd_en = rsp_phase && !resp_fifo_empty && !cap_pend && (rsp_idx < NW9);
    assign busy            = active;
    assign done            = (state == S_DONE);
    assign pass            = done && !timeout && (err_count == 8'd0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start_edge) state_nxt = S_WRITE;
            S_WRITE:        if (issuing && wr_idx == LAST) state_nxt = S_READ;
            S_READ:         if (issuing && wr_idx == LAST) state_nxt = S_DRAIN;
            S_DRAIN:        if ((capture && rsp_idx == LAST) || rsp_idx == NW9) state_nxt = S_DONE;
            default:        state_nxt = S_IDLE;
        endcase
        if (tmo_hit) state_nxt = S_DONE;
    end

    always_ff @(posedge clk_90mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= S_IDLE;
            start_q        <= 1'b0;
            wr_idx         <= '0;
            rsp_idx        <= '0;
            cap_pend       <= 1'b0;
            tmo_cnt        <= '0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= start;
            if (restart) begin
                wr_idx         <= '0;
                rsp_idx        <= '0;
                cap_pend       <= 1'b0;
                tmo_cnt        <= '0;
                timeout        <= 1'b0;
                err_count      <= '0;
                first_err_addr <= '0;
            end else if (active) begin
                cap_pend <= resp_fifo_rd_en;
                if (issuing)
                    wr_idx <= (wr_idx == LAST) ? 9'd0 : wr_idx + 9'd1;
                if (capture)
                    rsp_idx <= rsp_idx + 9'd1;
                if (mismatch) begin
                    if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                    if (err_count == 8'd0)  first_err_addr <= rsp_addr;
                end
                tmo_cnt <= (issuing || capture) ? '0 : tmo_cnt + TW'(1);
                if (tmo_hit) timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_bist_sequencer.sv
// Bench for bist_sequencer: two instances (base 0x00 and 0xF8) on a loopback memory
// with controllable FIFO backpressure, corruption and response withholding.
module tb_bist_sequencer;
    localparam int         NW   = 16;
    localparam int         TMO  = 64;
    localparam logic [7:0] SEED = 8'hA5;

    logic clk_90mhz = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 clk_90mhz = ~clk_90mhz;

    logic        start    [2] = '{1'b0, 1'b0};
    logic        cmd_full [2] = '{1'b0, 1'b0};
    logic        empty    [2] = '{1'b1, 1'b1};
    logic [7:0]  rdata    [2] = '{8'h00, 8'h00};
    logic        wr_en [2], rd_en [2], busy [2], done [2], pass [2], tmo [2];
    logic [16:0] cmd_data [2];
    logic [7:0]  errc [2], ferr [2];

    // memory / FIFO model state and knobs
    int          corrupt_a [2], corrupt_b [2], full_after [2], full_len [2], answer_lim [2];
    bit          rand_full [2], rand_stall [2];
    int          ncmd [2], nwr [2], nrd [2], full_cnt [2], viol [2];
    int          rwp [2] = '{0, 0};
    int          rrp [2] = '{0, 0};
    time         last_rd_t [2];
    logic [7:0]  mem  [2][256];
    logic [7:0]  rbuf [2][512];
    logic [16:0] clog [2][1024];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        bist_sequencer #(
            .NUM_WORDS(NW), .BASE_ADDR((g == 0) ? 8'h00 : 8'hF8),
            .SEED(SEED), .TIMEOUT_CYCLES(TMO)
        ) dut (
            .clk_90mhz(clk_90mhz), .sys_rst_n(sys_rst_n), .start(start[g]),
            .cmd_fifo_wr_en(wr_en[g]), .cmd_fifo_data(cmd_data[g]), .cmd_fifo_full(cmd_full[g]),
            .resp_fifo_rd_en(rd_en[g]), .resp_fifo_data(rdata[g]), .resp_fifo_empty(empty[g]),
            .busy(busy[g]), .done(done[g]), .pass(pass[g]), .timeout(tmo[g]),
            .err_count(errc[g]), .first_err_addr(ferr[g])
        );
    end

    always @(posedge clk_90mhz) begin
        for (int i = 0; i < 2; i++) begin
            logic [7:0] a, d;
            bit fh;
            if (wr_en[i]) begin
                if (cmd_full[i]) viol[i]++;
                if (ncmd[i] < 1024) clog[i][ncmd[i]] = cmd_data[i];
                ncmd[i]++;
                a = cmd_data[i][15:8];
                if (cmd_data[i][16]) begin
                    mem[i][a] = cmd_data[i][7:0];
                    nwr[i]++;
                end else begin
                    if (answer_lim[i] < 0 || nrd[i] < answer_lim[i]) begin
                        d = mem[i][a];
                        if (int'(a) == corrupt_a[i] || int'(a) == corrupt_b[i]) d = d ^ 8'hA0;
                        rbuf[i][rwp[i] % 512] = d;
                        rwp[i]++;
                    end
                    nrd[i]++;
                end
            end
            if (rd_en[i]) begin
                rdata[i] <= rbuf[i][rrp[i] % 512];
                rrp[i]++;
                last_rd_t[i] = $time;
            end
            fh = full_after[i] >= 0 && nwr[i] == full_after[i] && full_cnt[i] < full_len[i];
            if (fh) full_cnt[i]++;
            cmd_full[i] <= fh || (rand_full[i] && $urandom_range(0, 2) == 0);
            empty[i]    <= (rwp[i] == rrp[i]) || (rand_stall[i] && $urandom_range(0, 2) == 0);
        end
    end

    int total = 0, passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] base_of(input int i);
        return (i == 0) ? 8'h00 : 8'hF8;
    endfunction

    // Expected command k: NW writes of addr^SEED, then NW reads, addresses wrapping mod 256.
    function automatic logic [16:0] exp_cmd(input int i, input int k);
        logic [7:0] a;
        a = base_of(i) + 8'(k % NW);
        return (k < NW) ? {1'b1, a, a ^ SEED} : {1'b0, a, 8'h00};
    endfunction

    task automatic ref_result(input int i, output int err, output int first, output int to);
        int answered;
        logic [7:0] a;
        answered = (answer_lim[i] < 0 || answer_lim[i] > NW) ? NW : answer_lim[i];
        err = 0; first = 0;
        for (int k = 0; k < answered; k++) begin
            a = base_of(i) + 8'(k);
            if (int'(a) == corrupt_a[i] || int'(a) == corrupt_b[i]) begin
                if (err == 0) first = int'(a);
                err++;
            end
        end
        to = (answered < NW) ? 1 : 0;
    endtask

    task automatic model_clear(input int i);
        ncmd[i] = 0; nwr[i] = 0; nrd[i] = 0; full_cnt[i] = 0; viol[i] = 0;
        corrupt_a[i] = -1; corrupt_b[i] = -1; full_after[i] = -1; full_len[i] = 0;
        answer_lim[i] = -1; rand_full[i] = 0; rand_stall[i] = 0;
    endtask

    task automatic pulse_start(input int i);
        @(negedge clk_90mhz); start[i] = 1'b1;
        @(negedge clk_90mhz); start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int busy_low);
        int n;
        n = 0; busy_low = 0;
        while (!done[i] && n < 3000) begin
            if (!busy[i]) busy_low++;
            @(negedge clk_90mhz);
            n++;
        end
    endtask

    task automatic check_run(input string nm, input int i, input int e_err, input int e_first,
                             input int e_pass, input int e_tmo);
        int bad;
        bad = -1;
        for (int k = 0; k < 2 * NW; k++)
            if (bad < 0 && clog[i][k] !== exp_cmd(i, k)) bad = k;
        chk({nm, ".done"}, done[i], 1);
        chk({nm, ".busy"}, busy[i], 0);
        chk({nm, ".pass"}, pass[i], e_pass);
        chk({nm, ".timeout"}, tmo[i], e_tmo);
        chk({nm, ".err_count"}, errc[i], e_err);
        chk({nm, ".first_err_addr"}, ferr[i], e_first);
        chk({nm, ".cmd_count"}, ncmd[i], 2 * NW);
        chk({nm, ".cmd_first_bad_idx"}, bad, -1);
        chk({nm, ".wr_en_while_full"}, viol[i], 0);
    endtask

    typedef struct {
        int inst, ca, cb, fafter, flen, alim;
        int e_err, e_first, e_pass, e_tmo;
    } vec_t;

    initial begin
        vec_t vecs [6];
        int   bl, err, first, to, lat, n, snap;
        logic [7:0] t;

        vecs[0] = '{0,  -1,  -1, -1,  0, -1, 0, 0,     1, 0};
        vecs[1] = '{0,   5,   9, -1,  0, -1, 2, 'h05,  0, 0};
        vecs[2] = '{0,  -1,  -1,  3, 20, -1, 0, 0,     1, 0};
        vecs[3] = '{0,  -1,  -1, -1,  0, 10, 0, 0,     0, 1};
        vecs[4] = '{1,  -1,  -1, -1,  0, -1, 0, 0,     1, 0};
        vecs[5] = '{1, 'hFE, 'h03, -1, 0, -1, 2, 'hFE, 0, 0};

        model_clear(0); model_clear(1);
        repeat (3) @(negedge clk_90mhz);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset%0d.flags", i), int'({busy[i], done[i], pass[i], tmo[i], wr_en[i], rd_en[i]}), 0);
            chk($sformatf("reset%0d.values", i), int'({errc[i], ferr[i]}), 0);
            chk($sformatf("reset%0d.cmd_data", i), int'(cmd_data[i]), 0);
        end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge clk_90mhz);

        for (int v = 0; v < 6; v++) begin
            int i;
            i = vecs[v].inst;
            model_clear(i);
            corrupt_a[i] = vecs[v].ca; corrupt_b[i] = vecs[v].cb;
            full_after[i] = vecs[v].fafter; full_len[i] = vecs[v].flen;
            answer_lim[i] = vecs[v].alim;
            pulse_start(i);
            wait_done(i, bl);
            check_run($sformatf("vec%0d", v), i, vecs[v].e_err, vecs[v].e_first,
                      vecs[v].e_pass, vecs[v].e_tmo);
            chk($sformatf("vec%0d.busy_dropped", v), bl, 0);
            if (v == 0) begin
                chk("vec0.first_write", int'(clog[0][0]), 'h100A5);
                chk("vec0.last_write", int'(clog[0][NW-1]), 'h10FAA);
            end
            if (v == 2) chk("vec2.full_cycles", full_cnt[0], 20);
            if (v == 3) begin
                lat = int'(($time - last_rd_t[0]) / 10);
                chk("vec3.timeout_latency_ok", int'(lat >= 60 && lat <= 66), 1);
            end
            repeat (3) @(negedge clk_90mhz);
        end

        // Second start edge while reading must not restart the test.
        model_clear(0);
        pulse_start(0);
        n = 0;
        while (ncmd[0] < NW + 2 && n < 500) begin @(negedge clk_90mhz); n++; end
        chk("midread.reached_read", int'(ncmd[0] >= NW + 2), 1);
        pulse_start(0);
        wait_done(0, bl);
        check_run("midread", 0, 0, 0, 1, 0);

        // Reset during WRITE: outputs drop at once, no further strobes, then a clean rerun.
        model_clear(0);
        pulse_start(0);
        n = 0;
        while (nwr[0] < 5 && n < 500) begin @(negedge clk_90mhz); n++; end
        chk("rst.reached_write", int'(nwr[0] >= 5), 1);
        sys_rst_n = 1'b0;
        #1;
        chk("rst.flags_now", int'({busy[0], done[0], pass[0], tmo[0], wr_en[0], rd_en[0]}), 0);
        chk("rst.cmd_data_now", int'(cmd_data[0]), 0);
        snap = ncmd[0];
        repeat (3) @(negedge clk_90mhz);
        chk("rst.no_strobes", ncmd[0], snap);
        chk("rst.done_low", done[0], 0);
        sys_rst_n = 1'b1;
        @(negedge clk_90mhz);
        model_clear(0);
        pulse_start(0);
        wait_done(0, bl);
        check_run("rst_rerun", 0, 0, 0, 1, 0);

        // Randomized backpressure, stalls and corruption against the reference model.
        for (int r = 0; r < 10; r++) begin
            int i;
            i = int'($urandom_range(0, 1));
            model_clear(i);
            t = base_of(i) + 8'($urandom_range(0, NW + 3));
            corrupt_a[i] = int'(t);
            t = base_of(i) + 8'($urandom_range(0, NW + 3));
            if ($urandom_range(0, 1) == 1) corrupt_b[i] = int'(t);
            rand_full[i] = 1'b1; rand_stall[i] = 1'b1;
            pulse_start(i);
            wait_done(i, bl);
            ref_result(i, err, first, to);
            check_run($sformatf("rand%0d", r), i, err, first, int'(err == 0 && to == 0), to);
            repeat (2) @(negedge clk_90mhz);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
